// File: rtl/inst_loader_pkg.sv
// rtl/inst_loader_pkg.sv - shared types and widths for the instruction loader
package inst_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int LEN_W          = 32;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// rtl/inst_loader_byte_packer.sv - packs little-endian bytes into 32-bit words
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    // Shift each new byte in from the top so the first byte ends up in bits [7:0]
    always_comb begin
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        word       = {byte_in, shreg_q[WORD_W-1:8]};
        word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
        if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shreg_d = word;
        end
    end

    // Byte counter and pack register; the counter wraps so phases reuse it back to back
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream program loader for instruction memory (option: INST_LOADER_CHECKSUM_EN)
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

`ifdef INST_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  widx_q, widx_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              fire;
    logic              pk_valid;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (pk_valid),
        .byte_in    (in_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // Handshake, next-state and registered write-port computation
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        widx_d      = widx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
        fire     = in_valid && in_ready;
        pk_valid = fire && ((state_q == S_LEN) || (state_q == S_DATA));

        case (state_q)
            S_LEN: begin
                if (word_valid) begin
                    len_d  = word;
                    widx_d = '0;
                    if (word == '0) begin
                        state_d = S_AFTER_DATA;
                    end else if (word > LEN_W'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
`ifdef INST_LOADER_CHECKSUM_EN
                if (fire) begin
                    csum_d = csum_q ^ in_byte;
                end
`endif
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = widx_q;
                    mem_wdata_d = word;
                    widx_d      = widx_q + 1'b1;
                    if (widx_q == len_q - 1'b1) begin
                        state_d = S_AFTER_DATA;
                    end
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (fire) begin
                    state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // State and write-port registers; reset takes priority over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LEN;
            len_q       <= '0;
            widx_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign cpu_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - self-checking bench for inst_loader
module tb_inst_loader;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic [7:0] m_bytes[$];
    wr_t        exp_w[$];
    wr_t        cap[$];
    bit         chk_en = 1'b0;
    bit         cmp_d, cmp_e;

    inst_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] le32(input int b);
        return {m_bytes[b+3], m_bytes[b+2], m_bytes[b+1], m_bytes[b]};
    endfunction

    // Stream outcome derived from the bytes accepted since reset
    function automatic void model_state(output bit d, output bit e);
        int          n;
        int          data_end;
        logic [31:0] len;
        d = 1'b0;
        e = 1'b0;
        n = m_bytes.size();
        if (n < 4) return;
        len = le32(0);
        if (len > DEPTH) begin
            e = 1'b1;
            return;
        end
        data_end = 4 + 4 * int'(len);
`ifdef INST_LOADER_CHECKSUM_EN
        if (n == data_end + 1) begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 4; i < data_end; i++) x ^= m_bytes[i];
            if (x == m_bytes[data_end]) d = 1'b1;
            else e = 1'b1;
        end
`else
        if (n == data_end) d = 1'b1;
`endif
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        int          n;
        logic [31:0] len;
        wr_t         w;
        m_bytes.push_back(b);
        n = m_bytes.size();
        if (n >= 8 && (n % 4) == 0) begin
            len = le32(0);
            if (len <= DEPTH && n <= 4 + 4 * int'(len)) begin
                w.a = 32'((n - 8) / 4);
                w.d = le32(n - 4);
                exp_w.push_back(w);
            end
        end
    endfunction

    // Per-cycle comparison of registered outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_we", {31'b0, mem_we}, {31'b0, exp_w.size() != 0});
            if (mem_we) begin
                wr_t c;
                c.a = mem_addr;
                c.d = mem_wdata;
                cap.push_back(c);
                if (exp_w.size() != 0) begin
                    wr_t w;
                    w = exp_w.pop_front();
                    chk("write_addr", mem_addr, w.a);
                    chk("write_data", mem_wdata, w.d);
                end
            end
            model_state(cmp_d, cmp_e);
            chk("done", {31'b0, done}, {31'b0, cmp_d});
            chk("err", {31'b0, err}, {31'b0, cmp_e});
            chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, !cmp_d});
        end
    end

    task automatic send(input logic [7:0] b);
        bit d, e, rdy;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        #1;
        model_state(d, e);
        rdy = !(d || e);
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        @(posedge clk);
        if (rdy) model_accept(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Reset with a byte offered in the same cycle; the byte must be dropped
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        @(posedge clk);
        m_bytes.delete();
        exp_w.delete();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        cap.delete();
    endtask

    task automatic send_stream1(input bit gaps);
        logic [7:0] s[12];
        s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 12; i++) begin
            send(s[i]);
            if (gaps) idle(i % 4);
        end
    endtask

    task automatic check_stream1_writes();
        chk("s1_count", 32'(cap.size()), 32'd2);
        if (cap.size() == 2) begin
            chk("s1_addr0", cap[0].a, 32'h0);
            chk("s1_data0", cap[0].d, 32'h12345678);
            chk("s1_addr1", cap[1].a, 32'h1);
            chk("s1_data1", cap[1].d, 32'hDEADBEEF);
        end
    endtask

    initial begin
        logic [7:0] x;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;

        // Two-word program
        do_reset();
        send_stream1(1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
        send(8'h2A);
`endif
        idle(3);
        check_stream1_writes();
        chk("t1_done", {31'b0, done}, 32'h1);
        chk("t1_hold", {31'b0, cpu_hold}, 32'h0);
        send(8'h55);
        idle(2);
        chk("t1_after_done_writes", 32'(cap.size()), 32'd2);

        // Empty program
        do_reset();
        repeat (4) send(8'h00);
`ifdef INST_LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        idle(2);
        chk("t2_done", {31'b0, done}, 32'h1);
        chk("t2_no_write", 32'(cap.size()), 32'd0);

        // Oversized length
        do_reset();
        send(8'h01); send(8'h02); send(8'h00); send(8'h00);
        idle(2);
        chk("t3_err", {31'b0, err}, 32'h1);
        chk("t3_in_ready", {31'b0, in_ready}, 32'h0);
        chk("t3_hold", {31'b0, cpu_hold}, 32'h1);
        send(8'h00);
        idle(2);
        chk("t3_no_write", 32'(cap.size()), 32'd0);

        // Idle gaps between bytes
        do_reset();
        send_stream1(1'b1);
`ifdef INST_LOADER_CHECKSUM_EN
        send(8'h2A);
`endif
        idle(3);
        check_stream1_writes();
        chk("t4_done", {31'b0, done}, 32'h1);

        // Reset mid-word, then a clean reload
        do_reset();
        send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        send(8'h78); send(8'h56);
        idle(1);
        do_reset();
        idle(2);
        chk("t5_no_partial_write", 32'(cap.size()), 32'd0);
        chk("t5_hold", {31'b0, cpu_hold}, 32'h1);
        send_stream1(1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
        send(8'h2A);
`endif
        idle(3);
        check_stream1_writes();

        // Largest legal program fills the last address
        do_reset();
        send(8'h00); send(8'h02); send(8'h00); send(8'h00);
        x = 8'h00;
        for (int j = 0; j < 4 * DEPTH; j++) begin
            send(8'(j) ^ 8'h5A);
            x ^= 8'(j) ^ 8'h5A;
        end
`ifdef INST_LOADER_CHECKSUM_EN
        send(x);
`endif
        idle(3);
        chk("depth_count", 32'(cap.size()), 32'(DEPTH));
        if (cap.size() == DEPTH) begin
            chk("depth_last_addr", cap[DEPTH-1].a, 32'(DEPTH - 1));
            chk("depth_last_data", cap[DEPTH-1].d, 32'hA5A4A7A6);
        end
        chk("depth_done", {31'b0, done}, 32'h1);

`ifdef INST_LOADER_CHECKSUM_EN
        // Bad checksum keeps writes but rejects the program
        do_reset();
        send_stream1(1'b0);
        send(8'h2B);
        idle(3);
        check_stream1_writes();
        chk("t6_err", {31'b0, err}, 32'h1);
        chk("t6_done", {31'b0, done}, 32'h0);
        chk("t6_hold", {31'b0, cpu_hold}, 32'h1);
`endif

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
